aes_keyram_multi: RTL and testbench

Round-key store for the AES datapath, and successor to the single-context AES-128 key RAM. It holds round-key schedules for NUM_SLOTS independent key contexts, each context being AES-128, AES-192 or AES-256. Keys are written by the key-expansion unit in WR_WIDTH-bit words. Keys are read out as full 128-bit round keys, in forward (encrypt) or reverse (decrypt) order, through a ready/valid sequencer that feeds the round engine.

---
 rtl/aes_keyram_multi.sv | 151 +++++++++++++++
 tb/tb_aes_keyram_multi.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_keyram_multi.sv
// Multi-context AES round-key store: per-slot word-wide write port, 128-bit
// round-key read sequencer with ready/valid handshake toward the round engine.
//
// state | meaning
// IDLE  | no sequence; waiting for start
// FETCH | reading R words of round idx into the shadow register
// HOLD  | round key presented with key_valid=1 until key_ready
module aes_keyram_multi #(
    parameter int WR_WIDTH   = 64,
    parameter int NUM_SLOTS  = 2,
    parameter int MAX_ROUNDS = 14,
    localparam int R     = 128 / WR_WIDTH,
    localparam int SW    = $clog2(NUM_SLOTS),
    localparam int DEPTH = (MAX_ROUNDS + 1) * R,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                kill,
    input  logic                en_wr,
    input  logic [SW-1:0]       slot_wr,
    input  logic [AW-1:0]       addr_wr,
    input  logic [WR_WIDTH-1:0] key_round_wr,
    input  logic                cfg_wr,
    input  logic [SW-1:0]       cfg_slot,
    input  logic [3:0]          cfg_nr,
    input  logic                start,
    input  logic [SW-1:0]       start_slot,
    input  logic                start_dec,
    input  logic                key_ready,
    output logic [127:0]        key_round_rd,
    output logic                key_valid,
    output logic                key_first,
    output logic                key_last,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                err
);
    localparam int FW = $clog2(R + 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t              state;
    logic [SW-1:0]       act_slot;
    logic                act_dec;
    logic [3:0]          act_nr;
    logic [3:0]          idx;
    logic [FW-1:0]       fcnt;
    logic [3:0]          nr_cfg [NUM_SLOTS];
    logic [127:0]        shadow;
    logic [127:0]        asm_key;
    logic [WR_WIDTH-1:0] rd_data;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic                collide;

    logic [WR_WIDTH-1:0] mem [NUM_SLOTS][2**AW];

    // fcnt counts issued reads; the word read on the previous edge lands at fcnt-1
    always_comb begin
        rd_en   = (state == FETCH) && (int'(fcnt) < R);
        rd_addr = AW'(int'(idx) * R + int'(fcnt));
        asm_key = shadow;
        if (fcnt != '0)
            asm_key[(int'(fcnt) - 1) * WR_WIDTH +: WR_WIDTH] = rd_data;
        collide = (state != IDLE) && en_wr && (slot_wr == act_slot);
    end

    always_ff @(posedge clk) begin
        if (en_wr)
            mem[slot_wr][addr_wr] <= key_round_wr;
        if (rd_en)
            rd_data <= mem[act_slot][rd_addr];
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state        <= IDLE;
            act_slot     <= '0;
            act_dec      <= 1'b0;
            act_nr       <= 4'd10;
            idx          <= 4'd0;
            fcnt         <= '0;
            shadow       <= '0;
            key_round_rd <= '0;
            key_valid    <= 1'b0;
            key_first    <= 1'b0;
            key_last     <= 1'b0;
            round_idx    <= 4'd0;
            busy         <= 1'b0;
            err          <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++)
                nr_cfg[i] <= 4'd10;
        end else begin
            err <= 1'b0;
            if (cfg_wr) begin
                if (cfg_nr inside {4'd10, 4'd12, 4'd14})
                    nr_cfg[cfg_slot] <= cfg_nr;
                else
                    err <= 1'b1;
            end
            // A write into the slot being streamed invalidates the sequence
            if (collide) begin
                state     <= IDLE;
                busy      <= 1'b0;
                key_valid <= 1'b0;
                err       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            act_slot <= start_slot;
                            act_dec  <= start_dec;
                            act_nr   <= nr_cfg[start_slot];
                            idx      <= start_dec ? nr_cfg[start_slot] : 4'd0;
                            fcnt     <= '0;
                            busy     <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        fcnt <= fcnt + 1'b1;
                        if (fcnt != '0)
                            shadow <= asm_key;
                        if (fcnt == FW'(R)) begin
                            key_round_rd <= asm_key;
                            key_valid    <= 1'b1;
                            round_idx    <= idx;
                            key_first    <= (idx == (act_dec ? act_nr : 4'd0));
                            key_last     <= (idx == (act_dec ? 4'd0 : act_nr));
                            state        <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (key_ready) begin
                            key_valid <= 1'b0;
                            if (key_last) begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                idx   <= act_dec ? idx - 4'd1 : idx + 4'd1;
                                fcnt  <= '0;
                                state <= FETCH;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_keyram_multi.sv
// Scoreboard bench for aes_keyram_multi (WR_WIDTH=64, NUM_SLOTS=2, MAX_ROUNDS=14):
// directed sequences push expected keys; a negedge monitor checks each accepted key.
module tb_aes_keyram_multi;
    localparam int R = 2;

    logic         clk;
    logic         kill;
    logic         en_wr;
    logic [0:0]   slot_wr;
    logic [4:0]   addr_wr;
    logic [63:0]  key_round_wr;
    logic         cfg_wr;
    logic [0:0]   cfg_slot;
    logic [3:0]   cfg_nr;
    logic         start;
    logic [0:0]   start_slot;
    logic         start_dec;
    logic         key_ready;
    logic [127:0] key_round_rd;
    logic         key_valid;
    logic         key_first;
    logic         key_last;
    logic [3:0]   round_idx;
    logic         busy;
    logic         err;

    aes_keyram_multi #(.WR_WIDTH(64), .NUM_SLOTS(2), .MAX_ROUNDS(14)) dut (
        .clk(clk), .kill(kill), .en_wr(en_wr), .slot_wr(slot_wr), .addr_wr(addr_wr),
        .key_round_wr(key_round_wr), .cfg_wr(cfg_wr), .cfg_slot(cfg_slot), .cfg_nr(cfg_nr),
        .start(start), .start_slot(start_slot), .start_dec(start_dec), .key_ready(key_ready),
        .key_round_rd(key_round_rd), .key_valid(key_valid), .key_first(key_first),
        .key_last(key_last), .round_idx(round_idx), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic         first;
        logic         last;
    } exp_t;
    exp_t sb[$];

    // FIPS-197 appendix C.1 schedule for key 000102..0f, in FIPS byte order
    logic [127:0] fips [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [127:0] key0(int r);
        logic [127:0] b;
        logic [127:0] o;
        b = fips[r];
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = b[127 - 8*i -: 8];
        return o;
    endfunction

    function automatic logic [127:0] key1(int r);
        return {32'h11110000 + 32'(r), 32'h22220000 + 32'(r),
                32'h33330000 + 32'(r), 32'h44440000 + 32'(r)};
    endfunction

    function automatic logic [127:0] key_of(int slot, int r);
        return (slot == 0) ? key0(r) : key1(r);
    endfunction

    always @(negedge clk) begin
        if (key_valid && key_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got key idx %0d, expected no key", round_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_key", key_round_rd, e.key);
                check("sb_idx", round_idx, e.idx);
                check("sb_first", key_first, e.first);
                check("sb_last", key_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(int slot, int nr, bit dec, int count);
        exp_t e;
        int r;
        for (int k = 0; k < count; k++) begin
            r = dec ? nr - k : k;
            e.key   = key_of(slot, r);
            e.idx   = 4'(r);
            e.first = (k == 0);
            e.last  = (r == (dec ? 0 : nr));
            sb.push_back(e);
        end
    endtask

    task automatic write_key(int slot, int r, logic [127:0] k);
        for (int w = 0; w < R; w++) begin
            en_wr        = 1'b1;
            slot_wr      = 1'(slot);
            addr_wr      = 5'(r * R + w);
            key_round_wr = k[w*64 +: 64];
            tick();
        end
        en_wr = 1'b0;
    endtask

    task automatic do_cfg(int slot, int nr);
        cfg_wr   = 1'b1;
        cfg_slot = 1'(slot);
        cfg_nr   = 4'(nr);
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_start(int slot, bit dec);
        start_slot = 1'(slot);
        start_dec  = dec;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_key(int idx, int max_cyc);
        int c;
        c = 0;
        while (!(key_valid && int'(round_idx) == idx) && c < max_cyc) begin
            tick();
            c++;
        end
        if (c >= max_cyc) check("wait_key_timeout", 128'(c), 128'(0));
    endtask

    // Runs a started sequence to completion, checking latency and end-of-sequence state
    task automatic run_seq(int stall_idx, int max_cyc);
        int cnt, cyc;
        bit stalled, done, pa, pl, pv;
        logic [127:0] hk;
        logic [3:0] hi;
        cnt = 0; cyc = 0; stalled = 0; done = 0;
        while (!done && cyc < max_cyc) begin
            if (key_valid && int'(round_idx) == stall_idx && !stalled) begin
                hk = key_round_rd;
                hi = round_idx;
                stalled = 1;
                key_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    start      = (s == 0);
                    start_slot = 1'b1;
                    tick();
                    cyc++;
                    check("stall_valid", key_valid, 1);
                    check("stall_key", key_round_rd, hk);
                    check("stall_idx", round_idx, hi);
                    check("stall_busy", busy, 1);
                end
                start = 1'b0;
                key_ready = 1'b1;
            end
            pa = key_valid && key_ready;
            pl = key_last;
            pv = key_valid;
            tick();
            cyc++;
            cnt++;
            if (!pv && key_valid) check("latency", 128'(cnt), 128'(R + 1));
            if (pa) begin
                cnt = 0;
                if (pl) begin
                    check("busy_after_last", busy, 0);
                    check("valid_after_last", key_valid, 0);
                    done = 1;
                end
            end
        end
        if (!done) check("run_seq_timeout", 128'(cyc), 128'(0));
    endtask

    task automatic check_zero(string tag);
        check({tag, "_key"}, key_round_rd, 0);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_first"}, key_first, 0);
        check({tag, "_last"}, key_last, 0);
        check({tag, "_idx"}, round_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        kill = 1'b1; en_wr = 1'b0; slot_wr = '0; addr_wr = '0; key_round_wr = '0;
        cfg_wr = 1'b0; cfg_slot = '0; cfg_nr = '0; start = 1'b0; start_slot = '0;
        start_dec = 1'b0; key_ready = 1'b1;
        tick();
        tick();
        check_zero("reset");
        kill = 1'b0;

        for (int r = 0; r <= 10; r++) write_key(0, r, key0(r));

        // encrypt slot 0
        push_range(0, 10, 0, 11);
        do_start(0, 0);
        run_seq(-1, 200);

        // decrypt slot 0
        push_range(0, 10, 1, 11);
        do_start(0, 1);
        run_seq(-1, 200);

        // slot 1 at Nr=14, then an illegal Nr
        do_cfg(1, 14);
        check("cfg_ok_err", err, 0);
        for (int r = 0; r <= 14; r++) write_key(1, r, key1(r));
        do_cfg(1, 11);
        check("cfg_bad_err", err, 1);
        tick();
        check("cfg_bad_err_pulse", err, 0);
        push_range(1, 14, 1, 15);
        do_start(1, 1);
        run_seq(-1, 300);

        // backpressure on round 3 with an ignored start
        push_range(0, 10, 0, 11);
        do_start(0, 0);
        run_seq(3, 250);
        check("stall_err", err, 0);

        // write to other slot is harmless, write to active slot aborts
        push_range(0, 10, 0, 4);
        do_start(0, 0);
        wait_key(2, 40);
        en_wr = 1'b1; slot_wr = 1'b1; addr_wr = 5'd29; key_round_wr = key1(14)[127:64];
        tick();
        en_wr = 1'b0;
        check("other_slot_busy", busy, 1);
        check("other_slot_err", err, 0);
        wait_key(4, 40);
        key_ready = 1'b0;
        en_wr = 1'b1; slot_wr = 1'b0; addr_wr = 5'd0; key_round_wr = key0(0)[63:0];
        tick();
        en_wr = 1'b0;
        check("collide_busy", busy, 0);
        check("collide_valid", key_valid, 0);
        check("collide_err", err, 1);
        tick();
        check("collide_err_pulse", err, 0);
        check("collide_sb_drained", 128'(sb.size()), 0);
        key_ready = 1'b1;

        // kill in FETCH of round 5
        push_range(0, 10, 0, 5);
        do_start(0, 0);
        wait_key(4, 60);
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check_zero("kill");
        check("kill_sb_drained", 128'(sb.size()), 0);

        // slot 1 back at Nr=10 and RAM intact
        push_range(1, 10, 1, 11);
        do_start(1, 1);
        run_seq(-1, 200);
        push_range(0, 10, 0, 11);
        do_start(0, 0);
        run_seq(-1, 200);

        tick();
        check("final_sb_drained", 128'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
